spi_master_ng: RTL and testbench

Parametrised next-generation SPI master. Standard CPOL/CPHA modes, programmable SCLK divider, 1..DW-bit full-duplex words, MSB- or LSB-first, NCS decoded chip selects. Sits between a register/command interface (req/ack handshake) and off-chip SPI slaves. Replaces per-waveform cycle programming with a fixed mode-based timing engine.

---
 rtl/spi_master_ng.sv | 217 +++++++++++++++++++++
 tb/tb_spi_master_ng.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ng.sv
// spi_master_ng: mode-based SPI master (CPOL/CPHA, half-period divider, 1..DW-bit words, decoded chip selects).
// Build option SPI_MASTER_NG_LOOPBACK_EN adds a loopback input that feeds mosi back into the sampler.
module spi_master_ng #(
    parameter int DW  = 32,
    parameter int NCS = 4,
    parameter int CW  = 16,
    parameter int SW  = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req,
    input  logic [7:0]     nb,
    input  logic           cpol,
    input  logic           cpha,
    input  logic           lsb_first,
    input  logic [CW-1:0]  half_div,
    input  logic [SW-1:0]  cs_sel,
    input  logic [DW-1:0]  wr_data,
    output logic [DW-1:0]  rd_data,
    output logic           ack,
    output logic           busy,
    output logic           sclk,
    output logic           mosi,
    input  logic           miso,
    output logic [NCS-1:0] cs_n,
`ifdef SPI_MASTER_NG_LOOPBACK_EN
    input  logic           loopback,
`endif
    output logic [2:0]     state_dbg
);
    // Command handshake: req is a level held until ack; ack stays high until req is seen low,
    // and a new transfer only starts from IDLE, so a held req never retriggers.
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_ACK} state_t;

    localparam logic [7:0] DW8 = 8'(DW);

    state_t         state_q, state_d;
    logic [7:0]     nb_q, nb_d;
    logic           cpol_q, cpol_d;
    logic           cpha_q, cpha_d;
    logic           lsb_q, lsb_d;
    logic [CW-1:0]  hm1_q, hm1_d;
    logic [CW-1:0]  div_q, div_d;
    logic [DW-1:0]  wr_q, wr_d;
    logic [DW-1:0]  rd_q, rd_d;
    logic [9:0]     edge_q, edge_d;
    logic [7:0]     tx_cnt_q, tx_cnt_d;
    logic [7:0]     rx_cnt_q, rx_cnt_d;
    logic           sclk_q, sclk_d;
    logic           mosi_q, mosi_d;
    logic           ack_q, ack_d;
    logic           busy_q, busy_d;
    logic [NCS-1:0] cs_n_q, cs_n_d;

    logic [7:0]     nb_in;
    logic [9:0]     two_nb;
    logic [9:0]     edge_nxt;
    logic           sample_in;

    function automatic logic [7:0] bit_pos(input logic [7:0] n, input logic lsb, input logic [7:0] idx);
        return lsb ? idx : 8'(n - 8'd1 - idx);
    endfunction

    function automatic logic pick_bit(input logic [DW-1:0] d, input logic [7:0] pos);
        logic [DW-1:0] sh;
        sh = d >> pos;
        return sh[0];
    endfunction

    // Out-of-range selects assert no line; the transfer still runs on sclk/mosi.
    function automatic logic [NCS-1:0] cs_decode(input logic [SW-1:0] sel);
        logic [NCS-1:0] m;
        m = '1;
        for (int i = 0; i < NCS; i++) begin
            if (sel == SW'(i)) m[i] = 1'b0;
        end
        return m;
    endfunction

    assign nb_in  = (nb == 8'd0 || nb > DW8) ? DW8 : nb;
    assign two_nb = {1'b0, nb_q, 1'b0};

`ifdef SPI_MASTER_NG_LOOPBACK_EN
    assign sample_in = loopback ? mosi_q : miso;
`else
    assign sample_in = miso;
`endif

    always_comb begin
        state_d  = state_q;
        nb_d     = nb_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        lsb_d    = lsb_q;
        hm1_d    = hm1_q;
        div_d    = div_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        edge_d   = edge_q;
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        ack_d    = ack_q;
        busy_d   = busy_q;
        cs_n_d   = cs_n_q;
        edge_nxt = edge_q + 10'd1;
        unique case (state_q)
            S_IDLE: begin
                sclk_d = cpol;
                mosi_d = 1'b0;
                if (req) begin
                    state_d  = S_SETUP;
                    nb_d     = nb_in;
                    cpol_d   = cpol;
                    cpha_d   = cpha;
                    lsb_d    = lsb_first;
                    hm1_d    = (half_div == '0) ? '0 : half_div - CW'(1);
                    wr_d     = wr_data;
                    div_d    = '0;
                    edge_d   = '0;
                    tx_cnt_d = '0;
                    rx_cnt_d = '0;
                    busy_d   = 1'b1;
                    cs_n_d   = cs_decode(cs_sel);
                    if (!cpha) begin
                        mosi_d   = pick_bit(wr_data, bit_pos(nb_in, lsb_first, 8'd0));
                        tx_cnt_d = 8'd1;
                    end
                end
            end
            S_SETUP, S_SHIFT, S_HOLD: begin
                if (div_q != hm1_q) begin
                    div_d = div_q + CW'(1);
                end else begin
                    div_d  = '0;
                    edge_d = edge_nxt;
                    if (edge_nxt <= two_nb) begin
                        sclk_d  = ~sclk_q;
                        state_d = (edge_nxt == two_nb) ? S_HOLD : S_SHIFT;
                        // Odd edges sample when cpha=0, even edges sample when cpha=1.
                        if (edge_nxt[0] != cpha_q) begin
                            rd_d = ((rx_cnt_q == 8'd0) ? '0 : rd_q)
                                 | (DW'(sample_in) << bit_pos(nb_q, lsb_q, rx_cnt_q));
                            rx_cnt_d = rx_cnt_q + 8'd1;
                        end else if (edge_nxt < two_nb) begin
                            mosi_d   = pick_bit(wr_q, bit_pos(nb_q, lsb_q, tx_cnt_q));
                            tx_cnt_d = tx_cnt_q + 8'd1;
                        end
                    end else begin
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                        cs_n_d  = '1;
                        mosi_d  = 1'b0;
                    end
                end
            end
            S_ACK: begin
                if (!req) begin
                    state_d = S_IDLE;
                    ack_d   = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            nb_q     <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            hm1_q    <= '0;
            div_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            edge_q   <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            cs_n_q   <= '1;
        end else begin
            state_q  <= state_d;
            nb_q     <= nb_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            lsb_q    <= lsb_d;
            hm1_q    <= hm1_d;
            div_q    <= div_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            edge_q   <= edge_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            cs_n_q   <= cs_n_d;
        end
    end

    assign rd_data   = rd_q;
    assign ack       = ack_q;
    assign busy      = busy_q;
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign cs_n      = cs_n_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_master_ng.sv
// Testbench for spi_master_ng: random transfers against an SPI slave model with a scoreboard on ack.
module tb_spi_master_ng;
  localparam int DW  = 32;
  localparam int NCS = 4;
  localparam int CW  = 16;
  localparam int SW  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           req = 1'b0;
  logic [7:0]     nb = '0;
  logic           cpol = 1'b0;
  logic           cpha = 1'b0;
  logic           lsb_first = 1'b0;
  logic [CW-1:0]  half_div = '0;
  logic [SW-1:0]  cs_sel = '0;
  logic [DW-1:0]  wr_data = '0;
  logic [DW-1:0]  rd_data;
  logic           ack, busy, sclk, mosi;
  logic           miso = 1'b0;
  logic [NCS-1:0] cs_n;
  logic [2:0]     state_dbg;
`ifdef SPI_MASTER_NG_LOOPBACK_EN
  logic           loopback = 1'b0;
`endif

  spi_master_ng #(.DW(DW), .NCS(NCS), .CW(CW), .SW(SW)) dut (
    .clk(clk), .rst(rst), .req(req), .nb(nb), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .half_div(half_div), .cs_sel(cs_sel), .wr_data(wr_data),
    .rd_data(rd_data), .ack(ack), .busy(busy), .sclk(sclk), .mosi(mosi),
    .miso(miso), .cs_n(cs_n),
`ifdef SPI_MASTER_NG_LOOPBACK_EN
    .loopback(loopback),
`endif
    .state_dbg(state_dbg));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int bpos(input int n, input bit lsb, input int i);
    return lsb ? i : n - 1 - i;
  endfunction

  // ---------------- scoreboard queues ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_tx_q[$];
  int            exp_at_q[$];
  int            exp_edges_q[$];

  // transfer description handed to the slave model
  int             gen = 0;
  int             cfg_nb, cfg_h, cfg_c0;
  bit             cfg_cpha, cfg_lsb;
  logic [NCS-1:0] cfg_cs;
  logic [DW-1:0]  cfg_word;

  // ---------------- slave model + monitor ----------------
  int             slv_gen = 0;
  bit             slv_on = 1'b0;
  int             slv_k = 0;
  int             s_nb, s_h, s_c0, s_tx_i, s_rx_i;
  bit             s_cpha, s_lsb;
  logic [NCS-1:0] s_cs;
  logic [DW-1:0]  s_word;
  logic [DW-1:0]  slv_rx = '0;
  logic           sclk_prev = 1'b0;
  logic           ack_prev = 1'b0;
  logic [DW-1:0]  e_rd, e_tx;
  int             e_at, e_edges;

  always @(negedge clk) begin
    if (rst) begin
      slv_on   = 1'b0;
      ack_prev = 1'b0;
    end else begin
      if (gen != slv_gen) begin
        slv_gen = gen;
        slv_on  = 1'b1;
        slv_k   = 0;
        s_nb = cfg_nb; s_h = cfg_h; s_c0 = cfg_c0; s_cpha = cfg_cpha; s_lsb = cfg_lsb;
        s_cs = cfg_cs; s_word = cfg_word;
        s_tx_i = 0; s_rx_i = 0; slv_rx = '0;
        if (!s_cpha) begin
          miso = s_word[bpos(s_nb, s_lsb, 0)];
          s_tx_i = 1;
        end
      end else if (slv_on && sclk !== sclk_prev) begin
        slv_k++;
        check("edge_time", cyc - s_c0, s_h * slv_k);
        check("cs_n_active", cs_n, s_cs);
        if (((slv_k % 2) == 1) == (s_cpha == 1'b0)) begin
          slv_rx[bpos(s_nb, s_lsb, s_rx_i)] = mosi;
          s_rx_i++;
        end else if (slv_k < 2 * s_nb) begin
          miso = s_word[bpos(s_nb, s_lsb, s_tx_i)];
          s_tx_i++;
        end
        if (slv_k == 2 * s_nb) slv_on = 1'b0;
      end
      if (ack && !ack_prev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: got ack=1 expected no ack (cycle %0d)", cyc);
        end else begin
          e_rd    = exp_q.pop_front();
          e_tx    = exp_tx_q.pop_front();
          e_at    = exp_at_q.pop_front();
          e_edges = exp_edges_q.pop_front();
          check("rd_data", rd_data, e_rd);
          check("ack_cycle", cyc, e_at);
          check("mosi_word", slv_rx, e_tx);
          check("edge_count", slv_k, e_edges);
          check("ack_busy", busy, 1);
          check("ack_cs_n", cs_n, (64'd1 << NCS) - 64'd1);
          check("ack_mosi", mosi, 0);
        end
      end
      ack_prev = ack;
    end
    sclk_prev = sclk;
  end

  // ---------------- driver tasks ----------------
  task automatic start_xfer(input int nb_in, input int h_in, input bit pol, input bit pha,
                            input bit lsb, input int cs, input logic [DW-1:0] wd,
                            input logic [DW-1:0] sw, input bit lb, output int nbe, output int he);
    logic [DW-1:0] mask;
    bit lb_eff;
    nbe = (nb_in == 0 || nb_in > DW) ? DW : nb_in;
    he  = (h_in == 0) ? 1 : h_in;
    mask = (nbe == DW) ? '1 : DW'((64'd1 << nbe) - 64'd1);
    lb_eff = 1'b0;
    @(negedge clk);
    nb = 8'(nb_in); cpol = pol; cpha = pha; lsb_first = lsb;
    half_div = CW'(h_in); cs_sel = SW'(cs); wr_data = wd;
`ifdef SPI_MASTER_NG_LOOPBACK_EN
    loopback = lb;
    lb_eff = lb;
`endif
    @(negedge clk);
    check("sclk_idle", sclk, pol);
    cfg_nb = nbe; cfg_h = he; cfg_cpha = pha; cfg_lsb = lsb; cfg_word = sw;
    cfg_cs = (cs < NCS) ? ~(NCS'(1) << cs) : {NCS{1'b1}};
    cfg_c0 = cyc + 1;
    exp_q.push_back(lb_eff ? (wd & mask) : (sw & mask));
    exp_tx_q.push_back(wd & mask);
    exp_at_q.push_back(cfg_c0 + he * (2 * nbe + 1));
    exp_edges_q.push_back(2 * nbe);
    req = 1'b1;
    gen++;
  endtask

  task automatic finish_xfer(input int nbe, input int he, input int hold);
    int budget, waited;
    budget = he * (2 * nbe + 1) + 20;
    waited = 0;
    while (!ack && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    if (!ack) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: got no ack after %0d cycles, required within %0d", waited, budget);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_ack", ack, 1);
      check("hold_cs_n", cs_n, (64'd1 << NCS) - 64'd1);
    end
    req = 1'b0;
    @(negedge clk);
    check("ack_low", ack, 0);
    check("busy_low", busy, 0);
  endtask

  task automatic run_xfer(input int nb_in, input int h_in, input bit pol, input bit pha,
                          input bit lsb, input int cs, input logic [DW-1:0] wd,
                          input logic [DW-1:0] sw, input bit lb, input int hold);
    int nbe, he;
    start_xfer(nb_in, h_in, pol, pha, lsb, cs, wd, sw, lb, nbe, he);
    finish_xfer(nbe, he, hold);
  endtask

  task automatic reset_mid_shift();
    int nbe, he, waited;
    start_xfer(8, 3, 1'b0, 1'b0, 1'b0, 0, $urandom, $urandom, 1'b0, nbe, he);
    waited = 0;
    while (slv_k < 7 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (slv_k < 7) begin
      total++;
      bad++;
      $display("FAIL reach_edge7: got %0d edges, required 7", slv_k);
    end
    exp_q.delete(); exp_tx_q.delete(); exp_at_q.delete(); exp_edges_q.delete();
    rst = 1'b1;
    #1;
    check("rst_cs_n", cs_n, (64'd1 << NCS) - 64'd1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_data", rd_data, 0);
    req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("init_cs_n", cs_n, (64'd1 << NCS) - 64'd1);
    check("init_sclk", sclk, 0);
    check("init_mosi", mosi, 0);
    check("init_ack", ack, 0);
    check("init_busy", busy, 0);
    check("init_rd_data", rd_data, 0);
    rst = 1'b0;

    // mode 0, 8 bits, H=2, slave returns 0x3C
    run_xfer(8, 2, 1'b0, 1'b0, 1'b0, 1, 32'hA5, 32'h3C, 1'b0, 0);
    // mode 3, full word via nb=0, H=1, LSB first
    run_xfer(0, 1, 1'b1, 1'b1, 1'b1, 2, 32'h12345678, $urandom, 1'b0, 0);
    // odd length, upper wr_data bits must not be sent
    run_xfer(5, 2, 1'b0, 1'b0, 1'b0, 0, 32'hFFFFFF13, $urandom, 1'b0, 0);
    // req held for 10 cycles after ack, then a fresh transfer
    run_xfer(8, 1, 1'b0, 1'b1, 1'b0, 3, $urandom, $urandom, 1'b0, 10);
    run_xfer(6, 2, 1'b1, 1'b0, 1'b1, 1, $urandom, $urandom, 1'b0, 0);
    // reset during shifting, then a normal transfer
    reset_mid_shift();
    run_xfer(8, 2, 1'b0, 1'b0, 1'b0, 1, $urandom, $urandom, 1'b0, 0);
    // unmapped chip select (and loopback when built in)
    run_xfer(8, 2, 1'b0, 1'b0, 1'b0, 5, $urandom, $urandom, 1'b1, 0);
    // length boundaries: single bit, over-long request, H=0
    run_xfer(1, 5, 1'b1, 1'b0, 1'b0, 0, $urandom, $urandom, 1'b0, 0);
    run_xfer(33, 0, 1'b0, 1'b1, 1'b1, 2, $urandom, $urandom, 1'b0, 0);

    for (int i = 0; i < 16; i++) begin
      run_xfer($urandom_range(0, 40), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
               $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
